// File: rtl/gpr_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arb_pkg
// Description : Shared types and constants for the GPR write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_wb_arb_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  REG_X0     = 5'd0;

    typedef enum logic [1:0] {
        SRC_EXU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/gpr_wb_arb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : gpr_scoreboard
// Description : Busy bits for long-latency destinations and RAW/WAW hazard stall.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_scoreboard
    import gpr_wb_arb_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_long_i,
    input  logic [REG_ADDR_W-1:0] iss_rd_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic                  rs1_used_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  rs2_used_i,
    input  logic                  rd_we_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  stall_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            w_set_en;

    assign stall_o  = (rs1_used_i & busy_q[rs1_i])
                    | (rs2_used_i & busy_q[rs2_i])
                    | (rd_we_i    & busy_q[rd_i]);

    assign w_set_en = iss_long_i & ~stall_o & (iss_rd_i != REG_X0);

    // Set is applied after clear so a same-edge set/clear leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (w_set_en) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arb
// Description : Write-back arbiter (EXU > LSU/MDU round-robin) driving the GPR write port.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arb
    import gpr_wb_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_we_i,
    input  logic [REG_ADDR_W-1:0] exu_rd_i,
    input  logic [XLEN-1:0]       exu_wdata_i,
    input  logic                  lsu_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]       lsu_wdata_i,
    output logic                  lsu_ready_o,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]       mdu_wdata_i,
    output logic                  mdu_ready_o,
    input  logic                  iss_long_i,
    input  logic [REG_ADDR_W-1:0] iss_rd_i,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic                  dec_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  dec_rs2_used_i,
    input  logic                  dec_rd_we_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    output logic                  stall_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]       wdata_o
);

    wb_src_e               rr_q, rr_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    logic                  w_lsu_gnt;
    logic                  w_mdu_gnt;
    logic                  w_win;
    logic [REG_ADDR_W-1:0] w_win_rd;
    logic [XLEN-1:0]       w_win_data;

    // Execute has no backpressure, so it always pre-empts the handshaked sources.
    always_comb begin
        w_lsu_gnt = 1'b0;
        w_mdu_gnt = 1'b0;
        rr_d      = rr_q;
        if (!rst && !exu_we_i) begin
            if (lsu_valid_i && mdu_valid_i) begin
                if (rr_q == SRC_LSU) begin
                    w_lsu_gnt = 1'b1;
                    rr_d      = SRC_MDU;
                end else begin
                    w_mdu_gnt = 1'b1;
                    rr_d      = SRC_LSU;
                end
            end else begin
                w_lsu_gnt = lsu_valid_i;
                w_mdu_gnt = mdu_valid_i;
            end
        end
    end

    assign lsu_ready_o = w_lsu_gnt;
    assign mdu_ready_o = w_mdu_gnt;

    always_comb begin
        w_win      = exu_we_i | w_lsu_gnt | w_mdu_gnt;
        w_win_rd   = exu_rd_i;
        w_win_data = exu_wdata_i;
        if (!exu_we_i && w_lsu_gnt) begin
            w_win_rd   = lsu_rd_i;
            w_win_data = lsu_wdata_i;
        end else if (!exu_we_i && w_mdu_gnt) begin
            w_win_rd   = mdu_rd_i;
            w_win_data = mdu_wdata_i;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (w_win && (w_win_rd != REG_X0)) begin
            we_d    = 1'b1;
            waddr_d = w_win_rd;
            wdata_d = w_win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rr_q    <= SRC_LSU;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    gpr_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_long_i (iss_long_i),
        .iss_rd_i   (iss_rd_i),
        .clr_en_i   (w_lsu_gnt | w_mdu_gnt),
        .clr_rd_i   (w_lsu_gnt ? lsu_rd_i : mdu_rd_i),
        .rs1_i      (dec_rs1_i),
        .rs1_used_i (dec_rs1_used_i),
        .rs2_i      (dec_rs2_i),
        .rs2_used_i (dec_rs2_used_i),
        .rd_we_i    (dec_rd_we_i),
        .rd_i       (dec_rd_i),
        .stall_o    (stall_o)
    );

    a_lsu_hold: assert property (@(posedge clk) disable iff (rst)
        (lsu_valid_i && !lsu_ready_o) |=>
            (!lsu_valid_i || ($stable(lsu_rd_i) && $stable(lsu_wdata_i))));

    a_mdu_hold: assert property (@(posedge clk) disable iff (rst)
        (mdu_valid_i && !mdu_ready_o) |=>
            (!mdu_valid_i || ($stable(mdu_rd_i) && $stable(mdu_wdata_i))));

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_arb
// Description : Directed scoreboard bench for the GPR write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_we_i;
    logic [4:0]  exu_rd_i;
    logic [31:0] exu_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_wdata_i;
    logic        mdu_ready_o;
    logic        iss_long_i;
    logic [4:0]  iss_rd_i;
    logic [4:0]  dec_rs1_i;
    logic        dec_rs1_used_i;
    logic [4:0]  dec_rs2_i;
    logic        dec_rs2_used_i;
    logic        dec_rd_we_i;
    logic [4:0]  dec_rd_i;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    always #5 clk = ~clk;

    gpr_wb_arb #(.XLEN(32), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .exu_we_i       (exu_we_i),
        .exu_rd_i       (exu_rd_i),
        .exu_wdata_i    (exu_wdata_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_ready_o    (lsu_ready_o),
        .mdu_valid_i    (mdu_valid_i),
        .mdu_rd_i       (mdu_rd_i),
        .mdu_wdata_i    (mdu_wdata_i),
        .mdu_ready_o    (mdu_ready_o),
        .iss_long_i     (iss_long_i),
        .iss_rd_i       (iss_rd_i),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs1_used_i (dec_rs1_used_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_rs2_used_i (dec_rs2_used_i),
        .dec_rd_we_i    (dec_rd_we_i),
        .dec_rd_i       (dec_rd_i),
        .stall_o        (stall_o),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic dec_idle();
        dec_rs1_i = 5'd0; dec_rs1_used_i = 1'b0;
        dec_rs2_i = 5'd0; dec_rs2_used_i = 1'b0;
        dec_rd_i  = 5'd0; dec_rd_we_i    = 1'b0;
    endtask

    // Write-port monitor: every we_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && we_o === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h expected none", waddr_o, wdata_o);
            end else begin
                chk("mon_waddr", {27'd0, waddr_o}, {27'd0, exp_addr_q.pop_front()});
                chk("mon_wdata", wdata_o, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        exu_we_i = 1'b0; exu_rd_i = 5'd0; exu_wdata_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_wdata_i = 32'd0;
        mdu_valid_i = 1'b0; mdu_rd_i = 5'd0; mdu_wdata_i = 32'd0;
        iss_long_i = 1'b0; iss_rd_i = 5'd0;
        dec_idle();

        // Reset while a load response is pending
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd5; lsu_wdata_i = 32'h55;
        iss_long_i = 1'b1; iss_rd_i = 5'd5;
        tick();
        tick();
        chk("rst_lsu_ready", {31'd0, lsu_ready_o}, 32'd0);
        chk("rst_we",        {31'd0, we_o}, 32'd0);
        chk("rst_waddr",     {27'd0, waddr_o}, 32'd0);
        chk("rst_wdata",     wdata_o, 32'd0);
        iss_long_i = 1'b0;
        rst = 1'b0;
        dec_rs1_i = 5'd5; dec_rs1_used_i = 1'b1;
        settle();
        chk("rst_busy_clear", {31'd0, stall_o}, 32'd0);
        chk("post_rst_lsu_ready", {31'd0, lsu_ready_o}, 32'd1);
        expect_wr(5'd5, 32'h55);
        tick();
        lsu_valid_i = 1'b0;
        dec_idle();
        settle();
        chk("post_rst_we", {31'd0, we_o}, 32'd1);

        // Execute pre-empts a pending load
        exu_we_i = 1'b1; exu_rd_i = 5'd3; exu_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_wdata_i = 32'h77;
        settle();
        chk("exu_blocks_lsu", {31'd0, lsu_ready_o}, 32'd0);
        expect_wr(5'd3, 32'h11);
        tick();
        exu_we_i = 1'b0;
        settle();
        chk("lsu_after_exu", {31'd0, lsu_ready_o}, 32'd1);
        expect_wr(5'd7, 32'h77);
        tick();
        lsu_valid_i = 1'b0;

        // Contended LSU/MDU round-robin
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd8; lsu_wdata_i = 32'h88;
        mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_wdata_i = 32'h99;
        settle();
        chk("rr0_lsu", {30'd0, lsu_ready_o, mdu_ready_o}, 32'b10);
        expect_wr(5'd8, 32'h88);
        tick();
        settle();
        chk("rr1_mdu", {30'd0, lsu_ready_o, mdu_ready_o}, 32'b01);
        expect_wr(5'd9, 32'h99);
        tick();
        settle();
        chk("rr2_lsu", {30'd0, lsu_ready_o, mdu_ready_o}, 32'b10);
        expect_wr(5'd8, 32'h88);
        tick();
        lsu_valid_i = 1'b0; mdu_valid_i = 1'b0;

        // RAW stall on a long-latency destination
        iss_long_i = 1'b1; iss_rd_i = 5'd10;
        settle();
        chk("iss10_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        iss_long_i = 1'b0;
        dec_rs1_i = 5'd10; dec_rs1_used_i = 1'b1;
        settle();
        chk("raw10_stall", {31'd0, stall_o}, 32'd1);
        tick();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_wdata_i = 32'hA0;
        settle();
        chk("raw10_stall_clr_cycle", {31'd0, stall_o}, 32'd1);
        chk("raw10_lsu_ready", {31'd0, lsu_ready_o}, 32'd1);
        expect_wr(5'd10, 32'hA0);
        tick();
        lsu_valid_i = 1'b0;
        settle();
        chk("raw10_released", {31'd0, stall_o}, 32'd0);
        tick();
        tick();
        chk("idle_we", {31'd0, we_o}, 32'd0);
        chk("idle_waddr_hold", {27'd0, waddr_o}, 32'd10);
        chk("idle_wdata_hold", wdata_o, 32'hA0);
        dec_idle();

        // Same-edge set and clear on x12: set wins
        iss_long_i = 1'b1; iss_rd_i = 5'd12;
        tick();
        iss_long_i = 1'b1; iss_rd_i = 5'd12;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_wdata_i = 32'hC0;
        settle();
        chk("setclr_lsu_ready", {31'd0, lsu_ready_o}, 32'd1);
        chk("setclr_no_stall", {31'd0, stall_o}, 32'd0);
        expect_wr(5'd12, 32'hC0);
        tick();
        iss_long_i = 1'b0;
        lsu_valid_i = 1'b0;
        dec_rd_i = 5'd12; dec_rd_we_i = 1'b1;
        settle();
        chk("waw12_stall", {31'd0, stall_o}, 32'd1);
        tick();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_wdata_i = 32'hC1;
        expect_wr(5'd12, 32'hC1);
        tick();
        lsu_valid_i = 1'b0;
        settle();
        chk("waw12_released", {31'd0, stall_o}, 32'd0);
        dec_idle();

        // x0 destination: accepted but never written or marked busy
        mdu_valid_i = 1'b1; mdu_rd_i = 5'd0; mdu_wdata_i = 32'hFFFF;
        settle();
        chk("x0_mdu_ready", {31'd0, mdu_ready_o}, 32'd1);
        tick();
        mdu_valid_i = 1'b0;
        settle();
        chk("x0_no_we", {31'd0, we_o}, 32'd0);
        iss_long_i = 1'b1; iss_rd_i = 5'd0;
        tick();
        iss_long_i = 1'b0;
        dec_rs1_i = 5'd0; dec_rs1_used_i = 1'b1;
        dec_rs2_i = 5'd0; dec_rs2_used_i = 1'b1;
        dec_rd_i  = 5'd0; dec_rd_we_i    = 1'b1;
        settle();
        chk("x0_never_busy", {31'd0, stall_o}, 32'd0);
        dec_rs1_i = 5'd10; dec_rs2_i = 5'd12; dec_rd_i = 5'd5;
        settle();
        chk("all_clear", {31'd0, stall_o}, 32'd0);
        dec_idle();

        tick();
        tick();
        chk("queue_drained", exp_addr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
